fir_coeff_loader: RTL and testbench

Upstream companion to the FIR filter. Receives N signed coefficients over a valid/ready stream, writes them into a shadow bank, then atomically swaps the shadow bank into the active bank that drives the FIR coefficient input. The swap happens only on a sample-boundary strobe, so the FIR never sees a half-updated coefficient set.

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_coeff_loader_if.sv | 15 +
 rtl/fir_coeff_bank.sv | 37 +++
 rtl/fir_coeff_loader.sv | 148 ++++++++++++++
 tb/tb_fir_coeff_loader.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared FIR definitions: default geometry, loader state encoding and a tap-slicing helper.
package fir_pkg;

    localparam int DEF_BITWIDTH = 16;
    localparam int DEF_N        = 16;
    localparam int DEF_IDXW     = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_SWAP = 2'd2
    } ldr_state_e;

    // Tap i of a flat coefficient bus at the default geometry.
    function automatic logic [DEF_BITWIDTH-1:0] tap_slice(
        input logic [DEF_N*DEF_BITWIDTH-1:0] flat,
        input int unsigned                   i
    );
        return flat[i*DEF_BITWIDTH +: DEF_BITWIDTH];
    endfunction

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Coefficient stream (valid/ready/data) between an upstream source and the loader.
interface fir_coeff_loader_if
    import fir_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH
) ();

    logic                coef_valid;
    logic                coef_ready;
    logic [BITWIDTH-1:0] coef_data;

    modport master (output coef_valid, output coef_data, input  coef_ready);
    modport slave  (input  coef_valid, input  coef_data, output coef_ready);

endinterface

// File: rtl/fir_coeff_bank.sv
// Shadow/active coefficient register banks; commit copies the whole shadow bank in one edge.
module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int N        = DEF_N,
    parameter int IDXW     = DEF_IDXW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [IDXW-1:0]       idx,
    input  logic [BITWIDTH-1:0]   data,
    input  logic                  commit,
    output logic [N*BITWIDTH-1:0] active_flat
);

    logic [N*BITWIDTH-1:0] shadow_q;
    logic [N*BITWIDTH-1:0] active_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            if (we) begin
                shadow_q[32'(idx)*BITWIDTH +: BITWIDTH] <= data;
            end
            if (commit) begin
                active_q <= shadow_q;
            end
        end
    end

    assign active_flat = active_q;

endmodule

// File: rtl/fir_coeff_loader.sv
// Loads N coefficients into a shadow bank and swaps them into the active bank on swap_ok.
// Define COEF_CHECKSUM_EN to require a trailing wrapping-sum checksum word per set.
module fir_coeff_loader
    import fir_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH,
    parameter int N        = DEF_N,
    parameter int IDXW     = DEF_IDXW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  swap_ok,
    fir_coeff_loader_if.slave     coef_s,
    output logic [N*BITWIDTH-1:0] coeffs_flat,
    output logic                  busy,
    output logic                  swap_pulse,
    output logic                  err
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    ldr_state_e    state_q;
    logic [IDXW-1:0] idx_q;
    logic          ready_q;
    logic          busy_q;
    logic          pulse_q;
    logic          err_q;
`ifdef COEF_CHECKSUM_EN
    logic                chk_q;
    logic [BITWIDTH-1:0] sum_q;
`endif

    logic hs_d;
    logic shadow_we_d;
    logic commit_d;

    assign hs_d = ready_q && coef_s.coef_valid;
`ifdef COEF_CHECKSUM_EN
    assign shadow_we_d = hs_d && !load_start && !chk_q;
`else
    assign shadow_we_d = hs_d && !load_start;
`endif
    assign commit_d = (state_q == WAIT_SWAP) && swap_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef COEF_CHECKSUM_EN
            chk_q   <= 1'b0;
            sum_q   <= '0;
`endif
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_start) begin
                        state_q <= LOAD;
                        idx_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
`ifdef COEF_CHECKSUM_EN
                        chk_q   <= 1'b0;
                        sum_q   <= '0;
`endif
                    end
                end
                LOAD: begin
                    // Abort outranks a same-cycle word: the set restarts from tap 0.
                    if (load_start) begin
                        idx_q <= '0;
                        err_q <= 1'b1;
`ifdef COEF_CHECKSUM_EN
                        chk_q <= 1'b0;
                        sum_q <= '0;
`endif
                    end else if (hs_d) begin
`ifdef COEF_CHECKSUM_EN
                        if (chk_q) begin
                            chk_q   <= 1'b0;
                            ready_q <= 1'b0;
                            if (coef_s.coef_data == sum_q) begin
                                state_q <= WAIT_SWAP;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                err_q   <= 1'b1;
                            end
                        end else begin
                            sum_q <= sum_q + coef_s.coef_data;
                            if (idx_q == LAST_IDX) begin
                                chk_q <= 1'b1;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end
`else
                        if (idx_q == LAST_IDX) begin
                            state_q <= WAIT_SWAP;
                            ready_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
`endif
                    end
                end
                WAIT_SWAP: begin
                    if (swap_ok) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        pulse_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    fir_coeff_bank #(
        .BITWIDTH (BITWIDTH),
        .N        (N),
        .IDXW     (IDXW)
    ) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (shadow_we_d),
        .idx         (idx_q),
        .data        (coef_s.coef_data),
        .commit      (commit_d),
        .active_flat (coeffs_flat)
    );

    assign coef_s.coef_ready = ready_q;
    assign busy              = busy_q;
    assign swap_pulse        = pulse_q;
    assign err               = err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader; optional checksum steps run when COEF_CHECKSUM_EN is defined.
module tb_fir_coeff_loader;
    import fir_pkg::*;

    localparam int BW = 16;
    localparam int N  = 16;

    logic          clk;
    logic          rst_n;
    logic          load_start;
    logic          swap_ok;
    logic [N*BW-1:0] coeffs_flat;
    logic          busy;
    logic          swap_pulse;
    logic          err;

    fir_coeff_loader_if #(.BITWIDTH(BW)) cif ();

    fir_coeff_loader #(
        .BITWIDTH (BW),
        .N        (N),
        .IDXW     (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .swap_ok     (swap_ok),
        .coef_s      (cif.slave),
        .coeffs_flat (coeffs_flat),
        .busy        (busy),
        .swap_pulse  (swap_pulse),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [BW-1:0]   words [N];
    logic [BW-1:0]   chk_adj;
    logic [N*BW-1:0] exp_a;
    logic [N*BW-1:0] exp_b;
    logic [N*BW-1:0] exp_c;

    task automatic check_b(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [N*BW-1:0] obs, input logic [N*BW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*BW-1:0] pack_words();
        logic [N*BW-1:0] f;
        f = '0;
        for (int i = 0; i < N; i++) f[i*BW +: BW] = words[i];
        return f;
    endfunction

    // Streams words[] (plus the checksum word when enabled); returns at the negedge after the last edge.
    task automatic stream(input bit toggle, input bit early_swap);
        int          nw;
        logic [BW-1:0] sum;
        logic [BW-1:0] chk_word;
        sum = '0;
        for (int i = 0; i < N; i++) sum += words[i];
        chk_word = sum + chk_adj;
        nw = N;
`ifdef COEF_CHECKSUM_EN
        nw = N + 1;
`endif
        for (int i = 0; i < nw; i++) begin
            if (toggle) begin
                cif.coef_valid = 1'b0;
                @(negedge clk);
            end
            cif.coef_valid = 1'b1;
            cif.coef_data  = (i < N) ? words[i] : chk_word;
            if (early_swap && i == nw - 1) swap_ok = 1'b1;
            @(negedge clk);
        end
        cif.coef_valid = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; load_start = 1'b0; swap_ok = 1'b0;
        cif.coef_valid = 1'b0; cif.coef_data = '0; chk_adj = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle with stray valid words that must be ignored.
        cif.coef_valid = 1'b1; cif.coef_data = 16'h1234;
        repeat (3) @(negedge clk);
        cif.coef_valid = 1'b0;
        repeat (7) @(negedge clk);
        check_w("idle_coeffs", coeffs_flat, '0);
        check_b("idle_busy",  busy, 1'b0);
        check_b("idle_ready", cif.coef_ready, 1'b0);
        check_b("idle_err",   err, 1'b0);
        check_b("idle_pulse", swap_pulse, 1'b0);

        // Set A: tap i == i, back-to-back, swap delayed 5 cycles.
        for (int i = 0; i < N; i++) words[i] = BW'(i);
        exp_a = pack_words();
        start_load();
        check_b("a_ready_on", cif.coef_ready, 1'b1);
        check_b("a_busy_on",  busy, 1'b1);
        stream(1'b0, 1'b0);
        check_b("a_ready_off", cif.coef_ready, 1'b0);
        repeat (5) @(negedge clk);
        check_w("a_pre_swap", coeffs_flat, '0);
        check_b("a_busy_wait", busy, 1'b1);
        check_b("a_no_pulse", swap_pulse, 1'b0);
        swap_ok = 1'b1;
        @(negedge clk);
        swap_ok = 1'b0;
        check_w("a_swapped", coeffs_flat, exp_a);
        check_b("a_pulse", swap_pulse, 1'b1);
        check_b("a_busy_off", busy, 1'b0);
        @(negedge clk);
        check_b("a_pulse_once", swap_pulse, 1'b0);

        // Set B: valid toggling, swap_ok already high in the first wait cycle.
        for (int i = 0; i < N; i++) words[i] = 16'hFF00 + BW'(i);
        exp_b = pack_words();
        start_load();
        stream(1'b1, 1'b1);
        check_w("b_pre_swap", coeffs_flat, exp_a);
        @(negedge clk);
        swap_ok = 1'b0;
        check_w("b_swapped", coeffs_flat, exp_b);
        check_w("b_tap15", (N*BW)'(tap_slice(coeffs_flat, 15)), (N*BW)'(16'hFF0F));
        check_b("b_pulse", swap_pulse, 1'b1);

        // Abort after 7 words, then a full set of 5s.
        @(negedge clk);
        start_load();
        cif.coef_data = 16'h0009;
        cif.coef_valid = 1'b1;
        repeat (7) @(negedge clk);
        cif.coef_valid = 1'b0;
        start_load();
        check_b("ab_err", err, 1'b1);
        check_b("ab_ready", cif.coef_ready, 1'b1);
        check_w("ab_active_kept", coeffs_flat, exp_b);
        for (int i = 0; i < N; i++) words[i] = 16'h0005;
        exp_c = pack_words();
        stream(1'b0, 1'b0);
        check_w("ab_no_swap", coeffs_flat, exp_b);
        check_b("ab_busy", busy, 1'b1);
        swap_ok = 1'b1;
        @(negedge clk);
        swap_ok = 1'b0;
        check_w("ab_swapped", coeffs_flat, exp_c);
        check_b("ab_err_sticky", err, 1'b1);

        // Reset pulse mid-load, then a clean load of set A.
        @(negedge clk);
        start_load();
        cif.coef_data = 16'h0007;
        cif.coef_valid = 1'b1;
        repeat (9) @(negedge clk);
        cif.coef_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_w("rst_coeffs", coeffs_flat, '0);
        check_b("rst_busy",  busy, 1'b0);
        check_b("rst_ready", cif.coef_ready, 1'b0);
        check_b("rst_err",   err, 1'b0);
        @(negedge clk);
        for (int i = 0; i < N; i++) words[i] = BW'(i);
        start_load();
        stream(1'b0, 1'b1);
        @(negedge clk);
        swap_ok = 1'b0;
        check_w("rst_reload", coeffs_flat, exp_a);
        check_b("rst_reload_pulse", swap_pulse, 1'b1);
        check_b("rst_reload_err", err, 1'b0);

`ifdef COEF_CHECKSUM_EN
        // Words 1..16 sum to 136; first send 135 (mismatch), then 136.
        @(negedge clk);
        for (int i = 0; i < N; i++) words[i] = BW'(i + 1);
        chk_adj = 16'hFFFF;
        start_load();
        stream(1'b0, 1'b0);
        check_b("ck_bad_err",  err, 1'b1);
        check_b("ck_bad_busy", busy, 1'b0);
        swap_ok = 1'b1;
        @(negedge clk);
        swap_ok = 1'b0;
        check_b("ck_bad_pulse", swap_pulse, 1'b0);
        check_w("ck_bad_active", coeffs_flat, exp_a);
        chk_adj = '0;
        start_load();
        check_b("ck_err_clr", err, 1'b0);
        stream(1'b0, 1'b1);
        @(negedge clk);
        swap_ok = 1'b0;
        check_b("ck_good_pulse", swap_pulse, 1'b1);
        check_w("ck_good_active", coeffs_flat, pack_words());
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
